// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter controller.
// Optional per-requester grant counters are enabled with SRAM_ARB_PERF_EN.
package sram_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned PERF_CNT_W     = 16;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational round-robin grant: the search starts one slot after ptr and wraps.
// Produces a one-hot grant plus its binary index; the pointer register lives in the caller.
module sram_arb_rr #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                gnt     = NUM_REQ'(1) << cand;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin front end for a single-port SRAM macro: zero sweep after reset, registered
// macro drive and 2-edge read latency. Define SRAM_ARB_PERF_EN for per-requester grant counters.
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             init_done,
    output logic                             sram_we,
    output logic                             sram_wmask,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [DATA_WIDTH-1:0]            sram_din,
    input  logic [DATA_WIDTH-1:0]            sram_dout,
    output logic [NUM_REQ*PERF_CNT_W-1:0]    perf_grant_cnt
);

    localparam int unsigned           IDX_W     = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [IDX_W-1:0]      PTR_RST   = IDX_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  init_addr_q, init_addr_d;
    logic                   init_done_q, init_done_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_we_q, s1_we_d;
    logic [ADDR_WIDTH-1:0]  s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0]  s1_din_q, s1_din_d;
    logic [IDX_W-1:0]       s1_id_q, s1_id_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0]       s2_id_q, s2_id_d;

    logic [NUM_REQ-1:0]     gnt_c;
    logic [IDX_W-1:0]       gnt_idx_c;
    logic                   sel_we_c;
    logic [ADDR_WIDTH-1:0]  sel_addr_c;
    logic [DATA_WIDTH-1:0]  sel_wdata_c;

    sram_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_c),
        .gnt_idx (gnt_idx_c)
    );

    assign req_ready = (state_q == ST_RUN) ? gnt_c : '0;

    // Payload mux for the granted requester; gnt_c is one-hot or zero.
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_we_c    = req_we[i];
                sel_addr_c  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_c = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = 1'b0;
        s1_we_d     = s1_we_q;
        s1_addr_d   = s1_addr_q;
        s1_din_d    = s1_din_q;
        s1_id_d     = s1_id_q;
        s2_valid_d  = s1_valid_q & ~s1_we_q & (state_q == ST_RUN);
        s2_id_d     = s1_id_q;
        case (state_q)
            ST_INIT: begin
                s1_valid_d  = 1'b1;
                s1_we_d     = 1'b1;
                s1_addr_d   = init_addr_q;
                s1_din_d    = '0;
                s1_id_d     = '0;
                init_addr_d = init_addr_q + ADDR_WIDTH'(1);
                if (init_addr_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (|gnt_c) begin
                    s1_valid_d = 1'b1;
                    s1_we_d    = sel_we_c;
                    s1_addr_d  = sel_addr_c;
                    s1_din_d   = sel_wdata_c;
                    s1_id_d    = gnt_idx_c;
                    rr_ptr_d   = gnt_idx_c;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
            rr_ptr_q    <= PTR_RST;
            s1_valid_q  <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_addr_q   <= '0;
            s1_din_q    <= '0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_we_q     <= s1_we_d;
            s1_addr_q   <= s1_addr_d;
            s1_din_q    <= s1_din_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
        end
    end

    assign sram_we    = s1_valid_q & s1_we_q;
    assign sram_wmask = 1'b1;
    assign sram_addr  = s1_addr_q;
    assign sram_din   = s1_din_q;
    assign init_done  = init_done_q;
    assign rsp_valid  = s2_valid_q ? (NUM_REQ'(1) << s2_id_q) : '0;
    assign rsp_rdata  = sram_dout;

`ifdef SRAM_ARB_PERF_EN
    logic [NUM_REQ-1:0][PERF_CNT_W-1:0] perf_q, perf_d;

    // Saturating per-requester acceptance counters; req_ready is already gated to RUN.
    always_comb begin
        perf_d = perf_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (perf_q[i] != '1)) begin
                perf_d[i] = perf_q[i] + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_grant_cnt = perf_q;
`else
    assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Self-checking bench for sram_arb_ctrl: sweep, directed vector table, mid-operation reset,
// and randomized traffic against a queue/array reference model. Honours SRAM_ARB_PERF_EN.
module tb_sram_arb_ctrl;

    localparam int NUM_REQ = 2;
    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int DEPTH   = 1024;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [DW-1:0]         rsp_rdata, sram_din, sram_dout;
    logic                  init_done, sram_we, sram_wmask;
    logic [AW-1:0]         sram_addr;
    logic [NUM_REQ*16-1:0] perf_grant_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arb_ctrl #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .init_done      (init_done),
        .sram_we        (sram_we),
        .sram_wmask     (sram_wmask),
        .sram_addr      (sram_addr),
        .sram_din       (sram_din),
        .sram_dout      (sram_dout),
        .perf_grant_cnt (perf_grant_cnt)
    );

    // Macro stand-in: never-written words return garbage so a missing sweep is visible.
    logic [DW-1:0] mem     [DEPTH];
    bit            written [DEPTH];
    always @(posedge clk) begin
        if (sram_we) begin
            mem[sram_addr]     <= sram_din;
            written[sram_addr] <= 1'b1;
            sram_dout          <= 32'hX;
        end else begin
            sram_dout <= written[sram_addr] ? mem[sram_addr] : 32'hBAD0_0BAD ^ 32'(sram_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (ptr + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reset for 'hold' edges, then watch the whole zero sweep.
    task automatic reset_and_sweep(input int hold, input string tag);
        int bad_we, bad_addr, bad_din, bad_rdy, bad_rsp, bad_done, bad_mask;
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (hold) @(posedge clk);
        #1;
        check({tag, "_rst_init_done"}, init_done, 0);
        check({tag, "_rst_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rst_req_ready"}, req_ready, 0);
        check({tag, "_rst_sram_we"}, sram_we, 0);
        check({tag, "_rst_perf"}, perf_grant_cnt, 0);
        rst_n     = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        bad_we = 0; bad_addr = 0; bad_din = 0; bad_rdy = 0; bad_rsp = 0; bad_done = 0; bad_mask = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk);
            #1;
            if (sram_we !== 1'b1) bad_we++;
            if (sram_addr !== AW'(i)) bad_addr++;
            if (sram_din !== '0) bad_din++;
            if (sram_wmask !== 1'b1) bad_mask++;
            if (rsp_valid !== '0) bad_rsp++;
            if (init_done !== (i == DEPTH - 1)) bad_done++;
            if (i < DEPTH - 1 && req_ready !== '0) bad_rdy++;
        end
        req_valid = '0;
        check({tag, "_sweep_we_bad"}, bad_we, 0);
        check({tag, "_sweep_addr_bad"}, bad_addr, 0);
        check({tag, "_sweep_din_bad"}, bad_din, 0);
        check({tag, "_sweep_wmask_bad"}, bad_mask, 0);
        check({tag, "_sweep_rsp_bad"}, bad_rsp, 0);
        check({tag, "_sweep_init_done_bad"}, bad_done, 0);
        check({tag, "_sweep_ready_bad"}, bad_rdy, 0);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    vec_t vec [14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle t ends with acceptance edge t; read data appears two cycles after acceptance.
        vec[0]  = '{2'b01, 2'b01, 10'h155, 10'h000, 32'hDEADBEEF, 32'h0,        2'b01, 2'b00, 32'h0};
        vec[1]  = '{2'b01, 2'b00, 10'h155, 10'h000, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
        vec[2]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0};
        vec[3]  = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00, 2'b01, 32'hDEADBEEF};
        vec[4]  = '{2'b01, 2'b01, 10'h001, 10'h000, 32'h11111111, 32'h0,        2'b01, 2'b00, 32'h0};
        vec[5]  = '{2'b10, 2'b10, 10'h000, 10'h002, 32'h0,        32'h22222222, 2'b10, 2'b00, 32'h0};
        vec[6]  = '{2'b11, 2'b00, 10'h001, 10'h002, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
        vec[7]  = '{2'b11, 2'b00, 10'h001, 10'h002, 32'h0,        32'h0,        2'b10, 2'b00, 32'h0};
        vec[8]  = '{2'b11, 2'b00, 10'h001, 10'h002, 32'h0,        32'h0,        2'b01, 2'b01, 32'h11111111};
        vec[9]  = '{2'b11, 2'b00, 10'h001, 10'h002, 32'h0,        32'h0,        2'b10, 2'b10, 32'h22222222};
        vec[10] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 32'h0,        32'h0,        2'b01, 2'b01, 32'h11111111};
        vec[11] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00, 2'b10, 32'h22222222};
        vec[12] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00, 2'b01, 32'h00000000};
        vec[13] = '{2'b00, 2'b00, 10'h000, 10'h000, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0};

        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        reset_and_sweep(3, "por");

        for (int t = 0; t < 14; t++) begin
            req_valid = vec[t].v;
            req_we    = vec[t].we;
            req_addr  = {vec[t].a1, vec[t].a0};
            req_wdata = {vec[t].wd1, vec[t].wd0};
            #1;
            check($sformatf("vec%0d_ready", t), req_ready, vec[t].exp_rdy);
            check($sformatf("vec%0d_rsp_valid", t), rsp_valid, vec[t].exp_rsp);
            if (vec[t].exp_rsp != 2'b00) check($sformatf("vec%0d_rsp_rdata", t), rsp_rdata, vec[t].exp_data);
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        // Read accepted, then reset lands on the very next edge: the response must vanish.
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {10'h155, 10'h000};
        #1;
        check("midrst_accept_ready", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_and_sweep(1, "midrst");

        begin
            logic [31:0]        ref_mem [DEPTH];
            rsp_t               q [$];
            rsp_t               e;
            bit                 pv [NUM_REQ];
            logic               pwe [NUM_REQ];
            logic [AW-1:0]      pa [NUM_REQ];
            logic [DW-1:0]      pd [NUM_REQ];
            logic [NUM_REQ-1:0] vv, exp_rsp, exp_rdy;
            logic [DW-1:0]      exp_dat;
            int                 ptr, g, edge_cnt;

            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
            ptr      = NUM_REQ - 1;
            edge_cnt = 0;
            for (int c = 0; c < 2000; c++) begin
                exp_rsp = '0;
                exp_dat = '0;
                if (q.size() > 0 && q[0].due == edge_cnt) begin
                    e       = q.pop_front();
                    exp_rsp = NUM_REQ'(1) << e.id;
                    exp_dat = e.data;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pv[i] && $urandom_range(0, 3) != 0) begin
                        pv[i]  = 1'b1;
                        pwe[i] = 1'($urandom_range(0, 1));
                        pa[i]  = AW'($urandom_range(0, 15));
                        pd[i]  = $urandom;
                    end
                    vv[i] = pv[i];
                    req_we[i] = pwe[i];
                    req_addr[i*AW +: AW] = pa[i];
                    req_wdata[i*DW +: DW] = pd[i];
                end
                req_valid = vv;
                #1;
                g = model_grant(vv, ptr);
                exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
                check($sformatf("rand%0d_ready", c), req_ready, exp_rdy);
                check($sformatf("rand%0d_rsp_valid", c), rsp_valid, exp_rsp);
                if (exp_rsp != '0) check($sformatf("rand%0d_rsp_rdata", c), rsp_rdata, exp_dat);
                @(posedge clk);
                edge_cnt++;
                if (g >= 0) begin
                    ptr = g;
                    if (pwe[g]) ref_mem[pa[g]] = pd[g];
                    else q.push_back('{edge_cnt + 1, g, ref_mem[pa[g]]});
                    pv[g] = 1'b0;
                end
                #1;
            end
            req_valid = '0;
        end

`ifdef SRAM_ARB_PERF_EN
        reset_and_sweep(1, "perf");
        req_we   = '0;
        req_addr = '0;
        req_valid = 2'b01;
        repeat (5) begin @(posedge clk); #1; end
        req_valid = 2'b10;
        repeat (3) begin @(posedge clk); #1; end
        req_valid = '0;
        check("perf_counts_5_3", perf_grant_cnt, {16'd3, 16'd5});
        req_valid = 2'b01;
        repeat (70000) begin @(posedge clk); #1; end
        req_valid = '0;
        check("perf_req0_saturated", perf_grant_cnt[15:0], 16'hFFFF);
        check("perf_req1_held", perf_grant_cnt[31:16], 16'd3);
`else
        check("perf_tied_zero", perf_grant_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Shares one single-port 1024x32 SRAM22 macro between NUM_REQ requesters using round-robin arbitration.
- After reset, sweeps the whole array to zero, because the silicon macro powers up with undefined contents.
- Registers all macro inputs and returns read data with a fixed 2-cycle latency, tagged to the requester that issued the read.
- Sits between bus-side clients and the macro instance in the SRAM wrapper.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 10: macro address width.
- DATA_WIDTH, 32: macro word width.
- RAM_DEPTH, 1<<ADDR_WIDTH: number of words swept during init.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; request accepted when valid&ready at posedge.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  NUM_REQ  one-hot read-data valid; no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- init_done  out  1  high once the zero sweep has completed.
- sram_we  out  1  to macro we.
- sram_wmask  out  1  to macro wmask; constant 1.
- sram_addr  out  ADDR_WIDTH  to macro addr.
- sram_din  out  DATA_WIDTH  to macro din.
- sram_dout  in  DATA_WIDTH  from macro dout.
- perf_grant_cnt  out  NUM_REQ*16  per-requester grant counters (see Optional Feature).

Behaviour:
- FSM states:
  - INIT: entered on reset. A counter init_addr starts at 0. Each cycle the block writes zero at init_addr and increments it. After the write to RAM_DEPTH-1, the FSM moves to RUN. INIT lasts RAM_DEPTH cycles after rst_n deasserts.
  - RUN: stays in RUN until the next reset.
- Reset values:
  - state=INIT, init_addr=0, init_done=0.
  - rr pointer=NUM_REQ-1, so requester 0 has priority first.
  - s1_valid=0, s2_valid=0.
  - rsp_valid=0, req_ready=0, perf counters=0.
- Arbitration (RUN only):
  - Search starts at rr_ptr+1 modulo NUM_REQ. The first index with req_valid set gets req_ready.
  - At most one ready bit is high per cycle. req_ready is combinational from req_valid.
  - On acceptance, rr_ptr becomes the granted index.
  - In INIT, req_ready is all zero.
- Stage 1 (posedge k, acceptance):
  - Registers s1_valid, s1_we, s1_addr, s1_din, s1_id.
  - In INIT, stage 1 is loaded with we=1, addr=init_addr, din=0.
  - With no grant, s1_valid=0. s1_addr and s1_din hold their values.
- Macro drive:
  - sram_we = s1_valid & s1_we.
  - sram_addr = s1_addr, sram_din = s1_din, sram_wmask = 1.
  - The macro captures at posedge k+1.
- Stage 2 (posedge k+1):
  - s2_valid = s1_valid & ~s1_we & (state==RUN); s2_id = s1_id.
  - rsp_valid[s2_id] = s2_valid; rsp_rdata = sram_dout.
  - Read data is therefore presented in the cycle after posedge k+1: latency 2 edges from acceptance.
  - rsp_rdata is don't-care when rsp_valid=0. The macro outputs X after writes, and the bench must not check rdata then.
- Writes produce no response.
- Throughput is one access per cycle, and a read can follow a write back-to-back.
- Ordering and hazards:
  - A write accepted at edge k followed by a read of the same address accepted at k+1 returns the new data.
  - The macro's write at k+1 precedes its read at k+2, so no forwarding is needed.
- init_done rises in the first RUN cycle and stays high until reset.
- Reset mid-operation:
  - In-flight stage 1 and stage 2 contents are dropped. No rsp_valid fires after reset.
  - The sweep restarts at address 0.
- A requester holding valid while not granted must keep addr, we and wdata stable until accepted.

Optional Feature:
- SRAM_ARB_PERF_EN defined:
  - One 16-bit counter per requester, incremented on each accepted request.
  - Saturates at 16'hFFFF.
  - Cleared by reset; does not count during INIT.
- Undefined: perf_grant_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package sram_arb_pkg holds:
  - FSM state enum {ST_INIT, ST_RUN}.
  - PERF_CNT_W=16.
  - Default width constants.
- Sub-module sram_arb_rr: a combinational round-robin grant with inputs req[NUM_REQ] and ptr, and outputs one-hot gnt and gnt_idx. The pointer register stays in the top level.

Test Plan:
- Reset then idle:
  - init_done=0 for exactly 1024 cycles with sram_we=1 and sram_din=0.
  - sram_addr steps 0..1023.
  - req_ready=0 throughout; afterwards init_done=1.
- Single requester:
  - After init, req0 writes 0xDEADBEEF to 0x155, then reads 0x155 on the next cycle.
  - rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF exactly 2 cycles after read acceptance.
- Contention:
  - Both requesters hold valid reads (req0 addr 0x001, req1 addr 0x002) for 4 cycles.
  - Grants alternate 0,1,0,1 and rsp_valid alternates 01,10,01,10 with matching data.
- Unwritten location: a read of 0x3FF after init returns 0x00000000.
- Mid-operation reset: rst_n asserted 1 cycle after a read is accepted → no rsp_valid; init restarts at address 0.
- SRAM_ARB_PERF_EN:
  - Drive 5 req0 and 3 req1 acceptances → perf_grant_cnt = {16'd3,16'd5}.
  - Force 70000 grants → the counter holds at 0xFFFF.
